// File: rtl/memory_controller.sv
// -----------------------------------------------------------------------------
// memory_controller
//   Open-page DRAM-style controller with one-bit data and a row buffer per bank.
//   It accepts one request word per cycle while idle and services it against
//   internal storage of 4 banks x 16 rows x 16 columns x 1 bit. Every accepted
//   request is classified as a page hit or a page miss and counted.
//
//   Ports
//     clk                 single clock, all state changes on the rising edge
//     rst_n               asynchronous active-low reset
//     instrucn[31:0]      request: [31]=valid [30]=write bit [9:8]=bank
//                         [7:4]=row [3:0]=col, all other bits ignored
//     write_enable        1=write, 0=read, sampled together with instrucn
//     out                 data of the last completed access (a write echoes its bit)
//     page_hit_counter    accepted requests that found their row already open
//     page_miss_counter   accepted requests that needed an activate
//
//   Parameters
//     T_RP   precharge duration in cycles (>=1)
//     T_RCD  activate duration in cycles (>=1)
// -----------------------------------------------------------------------------
module memory_controller #(
    parameter int T_RP  = 2,
    parameter int T_RCD = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instrucn,
    input  logic        write_enable,
    output logic        out,
    output logic [31:0] page_hit_counter,
    output logic [31:0] page_miss_counter
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRECHARGE = 2'd1,
        ACTIVATE  = 2'd2,
        ACCESS    = 2'd3
    } state_t;

    // Terminal values of the shared phase counter.
    localparam logic [7:0] RP_LAST  = 8'(T_RP - 1);
    localparam logic [7:0] RCD_LAST = 8'(T_RCD - 1);

    state_t                  r_state;
    logic [1:0]              r_bank;
    logic [3:0]              r_row;
    logic [3:0]              r_col;
    logic                    r_wdata;
    logic                    r_we;
    logic [7:0]              r_cnt;
    logic [3:0]              r_open;
    logic [3:0][3:0]         r_open_row;
    logic [3:0][15:0][15:0]  r_mem;

    logic       w_valid;
    logic [1:0] w_bank;
    logic [3:0] w_row;
    logic [3:0] w_col;
    logic       w_hit;
    logic       w_unused;

    assign w_valid  = instrucn[31];
    assign w_bank   = instrucn[9:8];
    assign w_row    = instrucn[7:4];
    assign w_col    = instrucn[3:0];
    assign w_hit    = r_open[w_bank] && (r_open_row[w_bank] == w_row);
    // Bits [29:10] carry no meaning for this block.
    assign w_unused = &{1'b0, instrucn[29:10]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= IDLE;
            r_bank            <= '0;
            r_row             <= '0;
            r_col             <= '0;
            r_wdata           <= 1'b0;
            r_we              <= 1'b0;
            r_cnt             <= '0;
            r_open            <= '0;
            r_open_row        <= '0;
            r_mem             <= '0;
            out               <= 1'b0;
            page_hit_counter  <= '0;
            page_miss_counter <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_bank  <= w_bank;
                        r_row   <= w_row;
                        r_col   <= w_col;
                        r_wdata <= instrucn[30];
                        r_we    <= write_enable;
                        r_cnt   <= '0;
                        if (w_hit) begin
                            page_hit_counter <= page_hit_counter + 32'd1;
                            r_state          <= ACCESS;
                        end else begin
                            page_miss_counter <= page_miss_counter + 32'd1;
                            // An open bank holding another row must close first.
                            r_state <= r_open[w_bank] ? PRECHARGE : ACTIVATE;
                        end
                    end
                end

                PRECHARGE: begin
                    if (r_cnt == RP_LAST) begin
                        r_open[r_bank] <= 1'b0;
                        r_cnt          <= '0;
                        r_state        <= ACTIVATE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                ACTIVATE: begin
                    if (r_cnt == RCD_LAST) begin
                        r_open[r_bank]     <= 1'b1;
                        r_open_row[r_bank] <= r_row;
                        r_cnt              <= '0;
                        r_state            <= ACCESS;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                ACCESS: begin
                    if (r_we) begin
                        r_mem[r_bank][r_row][r_col] <= r_wdata;
                        out                         <= r_wdata;
                    end else begin
                        out <= r_mem[r_bank][r_row][r_col];
                    end
                    // Row stays open after the access.
                    r_state <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_controller.sv
module tb_memory_controller;

    logic        clk;
    logic        rst_n;
    logic [31:0] instrucn;
    logic        write_enable;
    logic        out;
    logic [31:0] page_hit_counter;
    logic [31:0] page_miss_counter;

    int total = 0;
    int bad   = 0;

    memory_controller #(.T_RP(2), .T_RCD(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .instrucn          (instrucn),
        .write_enable      (write_enable),
        .out               (out),
        .page_hit_counter  (page_hit_counter),
        .page_miss_counter (page_miss_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs/outputs then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge (the accept edge E0), then idle the bus.
    task automatic send(input logic [31:0] instr, input logic we);
        instrucn     = instr;
        write_enable = we;
        step();
        instrucn     = 32'h0;
        write_enable = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instrucn = 32'h0;
        write_enable = 1'b0;
        #12;
        total++; if (out !== 1'b0) begin bad++; $display("FAIL reset_out got=%0b exp=0", out); end
        total++; if (page_hit_counter !== 32'd0) begin bad++; $display("FAIL reset_hit got=%0d exp=0", page_hit_counter); end
        total++; if (page_miss_counter !== 32'd0) begin bad++; $display("FAIL reset_miss got=%0d exp=0", page_miss_counter); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Closed-bank write: miss, out updates at E3.
    task automatic test_write_miss();
        send(32'hC000_0035, 1'b1);
        total++; if (page_miss_counter !== 32'd1) begin bad++; $display("FAIL wmiss_miss got=%0d exp=1", page_miss_counter); end
        total++; if (page_hit_counter !== 32'd0) begin bad++; $display("FAIL wmiss_hit got=%0d exp=0", page_hit_counter); end
        step(); step();
        total++; if (out !== 1'b0) begin bad++; $display("FAIL wmiss_out_e2 got=%0b exp=0", out); end
        step();
        total++; if (out !== 1'b1) begin bad++; $display("FAIL wmiss_out_e3 got=%0b exp=1", out); end
    endtask

    // Hits on the open row: read 1, write 0 to a neighbour, read it back.
    task automatic test_read_hit();
        send(32'h8000_0035, 1'b0);
        total++; if (page_hit_counter !== 32'd1) begin bad++; $display("FAIL hit_cnt1 got=%0d exp=1", page_hit_counter); end
        total++; if (page_miss_counter !== 32'd1) begin bad++; $display("FAIL hit_miss1 got=%0d exp=1", page_miss_counter); end
        step();
        total++; if (out !== 1'b1) begin bad++; $display("FAIL hit_out1 got=%0b exp=1", out); end
        send(32'h8000_0036, 1'b1);   // write bit 0 to col6
        step();
        total++; if (out !== 1'b0) begin bad++; $display("FAIL hit_wr0 got=%0b exp=0", out); end
        send(32'h8000_0035, 1'b0);
        step();
        total++; if (out !== 1'b1) begin bad++; $display("FAIL hit_rd35 got=%0b exp=1", out); end
        send(32'h8000_0036, 1'b0);
        step();
        total++; if (out !== 1'b0) begin bad++; $display("FAIL hit_rd36 got=%0b exp=0", out); end
        total++; if (page_hit_counter !== 32'd4) begin bad++; $display("FAIL hit_cnt4 got=%0d exp=4", page_hit_counter); end
        total++; if (page_miss_counter !== 32'd1) begin bad++; $display("FAIL hit_miss_keep got=%0d exp=1", page_miss_counter); end
    endtask

    // Row conflict in bank0: precharge + activate, out updates at E5.
    task automatic test_conflict();
        send(32'h8000_0035, 1'b0);   // leave out=1 so the conflict read is visible
        step();
        send(32'h8000_0045, 1'b0);
        total++; if (page_miss_counter !== 32'd2) begin bad++; $display("FAIL conf_miss2 got=%0d exp=2", page_miss_counter); end
        step(); step(); step(); step();
        total++; if (out !== 1'b1) begin bad++; $display("FAIL conf_out_e4 got=%0b exp=1", out); end
        step();
        total++; if (out !== 1'b0) begin bad++; $display("FAIL conf_out_e5 got=%0b exp=0", out); end
        send(32'h8000_0035, 1'b0);
        total++; if (page_miss_counter !== 32'd3) begin bad++; $display("FAIL conf_miss3 got=%0d exp=3", page_miss_counter); end
        step(); step(); step(); step(); step();
        total++; if (out !== 1'b1) begin bad++; $display("FAIL conf_back got=%0b exp=1", out); end
        total++; if (page_hit_counter !== 32'd5) begin bad++; $display("FAIL conf_hit got=%0d exp=5", page_hit_counter); end
    endtask

    // Rows open in banks 1 and 2 simultaneously; alternating reads all hit.
    task automatic test_multi_bank();
        send(32'hC000_0121, 1'b1);   // bank1 row2 col1 <= 1
        step(); step(); step();
        total++; if (out !== 1'b1) begin bad++; $display("FAIL mb_w1 got=%0b exp=1", out); end
        send(32'h8000_0270, 1'b0);   // bank2 row7 col0
        step(); step(); step();
        total++; if (out !== 1'b0) begin bad++; $display("FAIL mb_r2 got=%0b exp=0", out); end
        total++; if (page_miss_counter !== 32'd5) begin bad++; $display("FAIL mb_miss5 got=%0d exp=5", page_miss_counter); end
        send(32'h8000_0121, 1'b0); step();
        total++; if (out !== 1'b1) begin bad++; $display("FAIL mb_alt1 got=%0b exp=1", out); end
        send(32'h8000_0270, 1'b0); step();
        total++; if (out !== 1'b0) begin bad++; $display("FAIL mb_alt2 got=%0b exp=0", out); end
        send(32'h8000_0121, 1'b0); step();
        total++; if (out !== 1'b1) begin bad++; $display("FAIL mb_alt3 got=%0b exp=1", out); end
        send(32'h8000_0035, 1'b0); step();   // bank0 row3 untouched by the others
        total++; if (out !== 1'b1) begin bad++; $display("FAIL mb_b0 got=%0b exp=1", out); end
        total++; if (page_hit_counter !== 32'd9) begin bad++; $display("FAIL mb_hit9 got=%0d exp=9", page_hit_counter); end
        total++; if (page_miss_counter !== 32'd5) begin bad++; $display("FAIL mb_miss_keep got=%0d exp=5", page_miss_counter); end
    endtask

    // Requests while busy and valid=0 words are dropped without side effects.
    task automatic test_drop();
        send(32'h8000_0312, 1'b0);   // bank3 closed miss
        instrucn     = 32'h8000_0035;  // write 0 to bank0 row3 col5, must be ignored
        write_enable = 1'b1;
        step(); step(); step();
        instrucn     = 32'h0;
        write_enable = 1'b0;
        total++; if (out !== 1'b0) begin bad++; $display("FAIL drop_out got=%0b exp=0", out); end
        total++; if (page_miss_counter !== 32'd6) begin bad++; $display("FAIL drop_miss got=%0d exp=6", page_miss_counter); end
        total++; if (page_hit_counter !== 32'd9) begin bad++; $display("FAIL drop_hit got=%0d exp=9", page_hit_counter); end
        send(32'h8000_0035, 1'b0); step();
        total++; if (out !== 1'b1) begin bad++; $display("FAIL drop_mem got=%0b exp=1", out); end
        instrucn     = 32'h4000_0035;  // valid=0
        write_enable = 1'b1;
        step(); step(); step();
        instrucn     = 32'h0;
        write_enable = 1'b0;
        total++; if (page_hit_counter !== 32'd10) begin bad++; $display("FAIL inv_hit got=%0d exp=10", page_hit_counter); end
        total++; if (page_miss_counter !== 32'd6) begin bad++; $display("FAIL inv_miss got=%0d exp=6", page_miss_counter); end
        total++; if (out !== 1'b1) begin bad++; $display("FAIL inv_hold got=%0b exp=1", out); end
    endtask

    // Reset during precharge clears everything including storage.
    task automatic test_reset_mid();
        send(32'h8000_0095, 1'b0);   // bank0 conflict -> PRECHARGE
        step();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out !== 1'b0) begin bad++; $display("FAIL rm_out got=%0b exp=0", out); end
        total++; if (page_hit_counter !== 32'd0) begin bad++; $display("FAIL rm_hit got=%0d exp=0", page_hit_counter); end
        total++; if (page_miss_counter !== 32'd0) begin bad++; $display("FAIL rm_miss got=%0d exp=0", page_miss_counter); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        send(32'h8000_0035, 1'b0);
        total++; if (page_miss_counter !== 32'd1) begin bad++; $display("FAIL rm_closed got=%0d exp=1", page_miss_counter); end
        step(); step(); step();
        total++; if (out !== 1'b0) begin bad++; $display("FAIL rm_cleared got=%0b exp=0", out); end
        total++; if (page_hit_counter !== 32'd0) begin bad++; $display("FAIL rm_hit_after got=%0d exp=0", page_hit_counter); end
    endtask

    initial begin
        test_reset();
        test_write_miss();
        step();
        test_read_hit();
        step();
        test_conflict();
        step();
        test_multi_bank();
        step();
        test_drop();
        step();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
